// File: rtl/mem_access_unit.sv
// mem_access_unit: RISC-V load/store sequencer in front of a word-wide RAM
// with a registered (one-cycle) read port. Loads extract and extend a byte,
// halfword or word lane; sub-word stores are done as read-modify-write
// because the RAM has no byte enables. The RAM read data arrives on mem_rd.
module mem_access_unit #(
    parameter int unsigned MEM_DEPTH = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_e      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_wd_q, mem_wd_d;

    logic        f3_illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Classify the incoming request from the live inputs (used only in IDLE)
    always_comb begin
        f3_illegal = 1'b0;
        if (is_store) begin
            f3_illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            f3_illegal = funct3 inside {3'b011, 3'b110, 3'b111};
        end
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        out_of_range = (addr >= 32'(MEM_DEPTH));
        req_err      = f3_illegal | misaligned | out_of_range;
    end

    // Lane extraction for loads and lane replacement for sub-word stores
    always_comb begin
        lane_b   = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = mem_rd[{addr_q[1], 4'b0000} +: 16];
        load_val = mem_rd;
        case (funct3_q)
            F3_B:    load_val = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_val = {24'h000000, lane_b};
            F3_H:    load_val = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_val = {16'h0000, lane_h};
            default: load_val = mem_rd;
        endcase
        merged = mem_rd;
        if (funct3_q == F3_B) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mem_wd_d   = mem_wd_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_d     = addr;
                    wdata_d    = wdata[15:0];
                    if (req_err) begin
                        state_d = S_ERR;
                    end else if (is_store && (funct3 == F3_W)) begin
                        // full-word store needs no read, data goes straight out
                        mem_wd_d = wdata;
                        state_d  = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = S_MERGE;
            end
            S_MERGE: begin
                if (is_store_q) begin
                    mem_wd_d = merged;
                    state_d  = S_WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mem_wd_q   <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            mem_wd_q   <= mem_wd_d;
        end
    end

    // Outputs decoded from state so mem_we falls as soon as reset asserts
    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE) || (state_q == S_ERR);
        err    = (state_q == S_ERR);
        mem_we = (state_q == S_WRITE);
        mem_a  = {addr_q[31:2], 2'b00};
        mem_wd = mem_wd_q;
        rdata  = rdata_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: word RAM model with registered read,
// hand-written vector table, corner-case sequences and randomized traffic
// checked against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int unsigned MEM_DEPTH = 128;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] mem_rd;
    logic        busy, done, err, mem_we;
    logic [31:0] rdata, mem_a, mem_wd;

    logic [31:0] ram [0:127];
    logic [31:0] model_mem [0:31];
    logic [31:0] model_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .is_store (is_store),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .mem_rd   (mem_rd),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem_we   (mem_we),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd)
    );

    // RAM with one-cycle registered read
    always @(posedge clk) begin
        if (mem_we) ram[mem_a[6:0]] <= mem_wd;
        mem_rd <= ram[mem_a[6:0]];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: outcome of one request computed from the ISA rules
    task automatic model_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output bit e, output int lat, output int wes);
        int          size;
        bit          ok_f3;
        logic [31:0] w, v, mask;
        int          sh;
        int          idx;
        ok_f3 = st ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        case (f3 % 4)
            0: size = 1;
            1: size = 2;
            default: size = 4;
        endcase
        e = !ok_f3 || ((a % size) != 0) || (a >= MEM_DEPTH);
        lat = 1;
        wes = 0;
        if (!e) begin
            idx  = int'(a / 4);
            sh   = int'(a % 4) * 8;
            w    = model_mem[idx];
            mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
            if (!st) begin
                v = (w >> sh) & mask;
                if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                model_rdata = v;
                lat = 3;
            end else begin
                model_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
                lat = (size == 4) ? 2 : 4;
                wes = 1;
            end
        end
    endtask

    // Drive one request at a negedge and observe until done plus one idle cycle
    task automatic do_txn(input string nm, input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit poke,
                          output int lat, output bit e, output int wes, output logic [31:0] got_rd);
        int busy_low;
        int addr_bad;
        lat = -1; e = 0; wes = 0; busy_low = 0; addr_bad = 0; got_rd = 'x;
        req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (poke && cyc == 1) begin
                req = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h60; wdata = 32'h0;
            end
            if (poke && cyc == 2) req = 1'b0;
            if (mem_we) wes++;
            if (!busy) busy_low++;
            if (mem_a !== {a[31:2], 2'b00}) addr_bad++;
            if (done) begin
                lat = cyc; e = err; got_rd = rdata;
                break;
            end
        end
        req = 1'b0;
        check({nm, " timeout"}, 32'(lat != -1), 32'd1);
        check({nm, " busy-low-while-active"}, 32'(busy_low), 32'd0);
        check({nm, " mem_a-stable"}, 32'(addr_bad), 32'd0);
        @(negedge clk);
        check({nm, " idle-after-done"}, {30'd0, busy, done}, 32'd0);
    endtask

    // Run a request through DUT and model and compare everything observable
    task automatic txn_check(input string nm, input bit st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output int lat, output bit e, output logic [31:0] got_rd);
        bit          me;
        int          ml, mw, wes;
        logic [6:0]  ix;
        model_txn(st, f3, a, wd, me, ml, mw);
        do_txn(nm, st, f3, a, wd, 1'b0, lat, e, wes, got_rd);
        check({nm, " err"},     32'(e),   32'(me));
        check({nm, " latency"}, 32'(lat), 32'(ml));
        check({nm, " we-count"}, 32'(wes), 32'(mw));
        check({nm, " rdata"},   got_rd,   model_rdata);
        if (a < MEM_DEPTH) begin
            ix = {a[6:2], 2'b00};
            check({nm, " ram"}, ram[ix], model_mem[a[6:2]]);
        end
    endtask

    task automatic add(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] r, input bit e, input int lat);
        vec_t v;
        v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.exp_rdata = r; v.exp_err = e; v.exp_lat = lat;
        tbl.push_back(v);
    endtask

    initial begin
        int          lat, wes;
        bit          e;
        logic [31:0] r;
        int          extra;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;

        add(1, 3'b010, 32'h64, 32'h8899AABB, 32'h00000000, 0, 2);
        add(0, 3'b000, 32'h64, 32'h0,        32'hFFFFFFBB, 0, 3);
        add(0, 3'b100, 32'h64, 32'h0,        32'h000000BB, 0, 3);
        add(0, 3'b001, 32'h66, 32'h0,        32'hFFFF8899, 0, 3);
        add(0, 3'b101, 32'h66, 32'h0,        32'h00008899, 0, 3);
        add(1, 3'b010, 32'h60, 32'h11223344, 32'h00008899, 0, 2);
        add(1, 3'b000, 32'h61, 32'h000000EE, 32'h00008899, 0, 4);
        add(0, 3'b010, 32'h60, 32'h0,        32'h1122EE44, 0, 3);
        add(1, 3'b001, 32'h62, 32'h1234CAFE, 32'h1122EE44, 0, 4);
        add(0, 3'b010, 32'h60, 32'h0,        32'hCAFEEE44, 0, 3);
        add(1, 3'b010, 32'h60, 32'hDEADBEEF, 32'hCAFEEE44, 0, 2);
        add(0, 3'b010, 32'h60, 32'h0,        32'hDEADBEEF, 0, 3);
        add(1, 3'b010, 32'h62, 32'h55555555, 32'hDEADBEEF, 1, 1);
        add(0, 3'b001, 32'h65, 32'h0,        32'hDEADBEEF, 1, 1);
        add(0, 3'b011, 32'h60, 32'h0,        32'hDEADBEEF, 1, 1);
        add(0, 3'b010, 32'h80, 32'h0,        32'hDEADBEEF, 1, 1);
        add(1, 3'b100, 32'h60, 32'h0,        32'hDEADBEEF, 1, 1);
        add(0, 3'b010, 32'h60, 32'h0,        32'hDEADBEEF, 0, 3);
        add(1, 3'b010, 32'h7C, 32'h0BADF00D, 32'hDEADBEEF, 0, 2);
        add(0, 3'b100, 32'h7F, 32'h0,        32'h0000000B, 0, 3);
        add(0, 3'b000, 32'h80, 32'h0,        32'h0000000B, 1, 1);
        add(0, 3'b010, 32'h7C, 32'h0,        32'h0BADF00D, 0, 3);

        // reset state
        repeat (2) @(negedge clk);
        check("reset ctl", {28'd0, busy, done, err, mem_we}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset mem_a", mem_a, 32'd0);
        check("reset mem_wd", mem_wd, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post-reset idle", {31'd0, busy}, 32'd0);

        // fill every RAM word through the DUT
        for (int i = 0; i < 32; i++) begin
            txn_check($sformatf("fill%0d", i), 1'b1, 3'b010, 32'(i * 4), $urandom, lat, e, r);
        end

        // vector table
        for (int i = 0; i < tbl.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            txn_check(nm, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, lat, e, r);
            check({nm, " tbl-rdata"}, r, tbl[i].exp_rdata);
            check({nm, " tbl-err"}, 32'(e), 32'(tbl[i].exp_err));
            check({nm, " tbl-lat"}, 32'(lat), 32'(tbl[i].exp_lat));
        end

        // req pulsed while busy with a load is ignored
        begin
            bit me; int ml, mw;
            model_txn(1'b0, 3'b010, 32'h64, 32'h0, me, ml, mw);
            do_txn("poke", 1'b0, 3'b010, 32'h64, 32'h0, 1'b1, lat, e, wes, r);
            check("poke lat", 32'(lat), 32'd3);
            check("poke rdata", r, 32'h8899AABB);
            check("poke we-count", 32'(wes), 32'd0);
            extra = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            check("poke extra-activity", 32'(extra), 32'd0);
            check("poke ram60", ram[7'h60], model_mem[24]);
        end

        // reset asserted while the sb write is pending
        txn_check("pre-abort sw", 1'b1, 3'b010, 32'h60, 32'h11223344, lat, e, r);
        req = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h61; wdata = 32'hEE;
        @(posedge clk);
        #1 req = 1'b0;
        extra = 0;
        while (!mem_we && extra < 10) begin
            @(negedge clk);
            extra++;
        end
        check("abort reached WRITE", {31'd0, mem_we}, 32'd1);
        check("abort write cycle", 32'(extra), 32'd3);
        reset_n = 1'b0;
        #1;
        check("abort ctl", {28'd0, busy, done, err, mem_we}, 32'd0);
        check("abort rdata", rdata, 32'd0);
        check("abort mem_a", mem_a, 32'd0);
        check("abort mem_wd", mem_wd, 32'd0);
        model_rdata = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        txn_check("post-abort lw", 1'b0, 3'b010, 32'h60, 32'h0, lat, e, r);
        check("post-abort word", r, 32'h11223344);

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom_range(0, 1));
            if (st) f3 = ($urandom_range(0, 3) == 3) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            else    f3 = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 143));
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            txn_check($sformatf("rnd%0d", i), st, f3, a, $urandom, lat, e, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit sitting directly upstream of the word-wide data RAM (ports clk, we, a, wd, rd; registered read, one-cycle latency).
- The multi-cycle controller hands it one RISC-V load/store per request. It performs byte/halfword/word loads with sign/zero extension.
- Sub-word stores are done as a read-modify-write, because the RAM has no byte enables.
- RAM entries are indexed by byte address of the word (word at byte address A lives at index A with A[1:0]=0).

Parameters:
- MEM_DEPTH, 128, number of RAM index slots; any access with addr >= MEM_DEPTH is an error.

Ports:
- clk  input  1  system clock, all state on posedge
- reset_n  input  1  asynchronous active-low reset
- req  input  1  start a transaction; sampled only in IDLE
- is_store  input  1  1 = store, 0 = load
- funct3  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr  input  32  byte address
- wdata  input  32  store data (low byte/half used for sb/sh)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at transaction end
- err  output  1  valid with done; misaligned/illegal/out-of-range
- rdata  output  32  load result; held until next successful load
- mem_we  output  1  to RAM we
- mem_a  output  32  to RAM a, always {addr_q[31:2],2'b00}
- mem_wd  output  32  to RAM wd

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, err=0, rdata=0, mem_we=0, mem_a=0, mem_wd=0. mem_we drops immediately on reset assertion, including mid-WRITE.
- IDLE: on posedge with req=1, latch is_store, funct3, addr, wdata, then classify:
  - err if funct3 is illegal: 011/110/111 for loads; anything except 000/001/010 for stores.
  - err if misaligned: h/hu with addr[0]=1; w with addr[1:0]!=0.
  - err if addr >= MEM_DEPTH.
  - Next state: on err -> ERR; sw -> WRITE; every other op -> READ.
- req while busy is ignored (not queued).
- READ: mem_a=word address, mem_we=0; the RAM captures rd on this state's closing edge. Next state MERGE.
- MERGE: rd is valid.
  - Load: extract lane addr_q[1:0] (little-endian: byte 0 = rd[7:0]); lb/lh sign-extend, lbu/lhu zero-extend; rdata registered on the closing edge; next DONE.
  - sb/sh: build merged word = rd with the selected lane replaced by wdata[7:0] or wdata[15:0]; register it into mem_wd; next WRITE.
- WRITE: mem_we=1, mem_a=word address, mem_wd=merged word (or wdata for sw). Exactly one write edge. Next DONE.
- DONE: done=1, err=0 for one cycle; next IDLE.
- ERR: done=1, err=1 for one cycle. mem_we is never asserted and rdata is unchanged; next IDLE.
- Latency, counted from the req-sampling edge to the done cycle:
  - error: 1
  - sw: 2 (WRITE, DONE)
  - load: 3 (READ, MERGE, DONE)
  - sb/sh: 4 (READ, MERGE, WRITE, DONE)
- A new req may be sampled in the cycle after done (IDLE); back-to-back transactions need no idle gap beyond that.
- mem_a is stable from READ through WRITE; no other state drives mem_we high.

Test Plan:
- RAM[0x64]=0x8899AABB: lb 0x64 -> rdata 0xFFFFFFBB; lbu 0x64 -> 0x000000BB; lh 0x66 -> 0xFFFF8899; lhu 0x66 -> 0x00008899. Each asserts done exactly 3 cycles after the req edge, err=0.
- RAM[0x60]=0x11223344: sb 0x61, wdata 0x000000EE -> RAM[0x60]=0x1122EE44. sh 0x62, wdata 0x1234CAFE -> 0xCAFEEE44. Exactly one mem_we pulse per store, done 4 cycles after req.
- sw 0x60, wdata 0xDEADBEEF -> RAM[0x60]=0xDEADBEEF, done 2 cycles after req; a following lw 0x60 -> rdata 0xDEADBEEF.
- Error cases: sw 0x62, lh 0x65, load funct3=011, lw 0x80 with MEM_DEPTH=128 -> each gives done=1, err=1 one cycle after req. mem_we stays 0, RAM unchanged, rdata retains its previous value.
- req pulsed during a busy load -> ignored, only one done.
- reset_n low during WRITE of sb 0x61 -> mem_we=0 immediately, all outputs return to reset values; after release, lw 0x60 returns the pre-store word 0x11223344 provided the write edge had not occurred.
